clkctrl_sync: RTL and testbench
===============================

# clkctrl_sync

Single-clock successor to the PHI2 clock controller: generates the CPU clock as a registered output of the high-speed clock, either by programmable division or by tracking a synchronised copy of the host low-speed clock. Switching between sources happens only in the PHI2 (high) phase, so no high or low phase is ever shortened. The block sits between the board clock inputs and the 65816 PHI2 pin. It also provides phase-edge strobes for downstream logic in the same clock domain.

## Interface
- DIV_W, 2, width of `cpuclk_div_sel`; the high-speed divide ratio is 2*(sel+1), giving 2..2^(DIV_W+1).
- SYNC_STAGES, 2, number of flops in the `lsclk_in` synchroniser; must be at least 2.
- hsclk_in  input  1  the only clock; every flop is rising-edge on it.
- rst  input  1  synchronous, active-high reset.
- lsclk_in  input  1  host low-speed clock, asynchronous to `hsclk_in`, treated as data.
- hsclk_sel  input  1  1 = run from the divided high-speed clock; 0 = track `lsclk_in`.
- cpuclk_div_sel  input  DIV_W  divide select; sampled only at phase boundaries.
- clkout  output  1  CPU clock (PHI2), registered.
- clk_rise  output  1  high for the first `hsclk_in` cycle in which `clkout` is 1.
- clk_fall  output  1  high for the first `hsclk_in` cycle in which `clkout` is 0.
- hsclk_selected  output  1  state == HS.
- lsclk_selected  output  1  state == LS.
- rdy  output  1  CPU RDY; see Configuration.

## Operation
- `lsclk_in` passes through SYNC_STAGES flops to give `ls_s`. A further flop gives `ls_p`.
  - Rise = `ls_s & !ls_p`.
  - Fall = `!ls_s & ls_p`.
- Registers: state, `cnt` (DIV_W bits), `div_q` (DIV_W bits), `clkout`.
- State LS:
  - `clkout <= ls_s` every cycle.
  - On a Rise with `hsclk_sel` = 1: `clkout <= 1`, `cnt <= 0`, `div_q <= cpuclk_div_sel`, state goes to HS.
- State HS:
  - When `cnt` != `div_q`: `cnt++`.
  - When `cnt` == `div_q`: `cnt <= 0` and `div_q <= cpuclk_div_sel`. Then:
    - If `clkout` = 1 and `hsclk_sel` = 0: hold `clkout` = 1 and go to HS2LS.
    - Otherwise: toggle `clkout`.
- State HS2LS:
  - `clkout` is held at 1.
  - On a Fall: `clkout <= 0`, state goes to LS.
  - If `hsclk_sel` returns to 1 before the Fall (abort): go to HS with `cnt <= 0`, `div_q <= cpuclk_div_sel`, and `clkout` staying 1.
- `clk_rise` and `clk_fall` are registered edge detects of `clkout`, i.e. they are derived from `clkout` and its previous value.
- Reset values:
  - State LS, `cnt` = 0, `div_q` = 0, `clkout` = 0.
  - `clk_rise` = 0, `clk_fall` = 0.
  - `lsclk_selected` = 1, `hsclk_selected` = 0, `rdy` = 1.
  - The synchroniser, `ls_s` and `ls_p` all reset to 0.
- Reset asserted mid-operation has the same effect in every state. `clkout` is 0 in the cycle after `rst` is sampled high.

## Timing
- LS mode: `clkout` lags `lsclk_in` by SYNC_STAGES+1 cycles, with ±1 cycle of synchroniser uncertainty.
- HS mode: high phase = low phase = `div_q`+1 cycles, so the period is 2*(`div_q`+1) cycles.
- A change on `cpuclk_div_sel` takes effect from the next phase boundary. No runt phase is ever produced.
- LS to HS: switch only on a synchronised LS rising edge. The first HS high phase is `div_q`+1 cycles, counted from that edge.
- HS to LS: the HS high phase always completes in full. `clkout` is then stretched high until the next synchronised LS fall, so the LS low phase is complete.
- `hsclk_sel` changing while `clkout` is low in HS: no effect until the end of the next high phase.
- If `lsclk_in` stops, the block waits indefinitely in LS or HS2LS. There is no timeout.

## Configuration
- Macro: `CLKCTRL_RDY_ON_CLKSW_EN`.
- Defined: `rdy` = `hsclk_sel ? (state==HS) : (state==LS)`. This is combinational from the state register and the `hsclk_sel` input, so `rdy` is 0 from a switch request until the switch completes, including throughout HS2LS.
- Undefined: `rdy` is constant 1.

## Structure
- Package `clkctrl_pkg` holds:
  - the state enum (LS, HS, HS2LS);
  - the divide-ratio helper function;
  - the default parameter constants.
- Sub-module `sync_bits`: a parametrised SYNC_STAGES-deep synchroniser with synchronous reset, used for `lsclk_in`.

## Test plan
- Reset, `hsclk_sel`=0, `lsclk_in` period 16 cycles (8 high / 8 low), SYNC_STAGES=2 -> `clkout` = `lsclk_in` delayed 3 cycles; `lsclk_selected`=1; `rdy`=1.
- `hsclk_sel`=1, `cpuclk_div_sel`=3 -> switch at the next LS rise; `clkout` then runs 4 high / 4 low; `hsclk_selected`=1.
- In HS, change `cpuclk_div_sel` from 3 to 0 mid-phase -> the current phase stays 4 cycles, then 1/1 phases follow; no phase shorter than its `div_q`+1.
- Drop `hsclk_sel` during an HS low phase -> the low phase and a full high phase complete, `clkout` is held high until the synchronised LS fall, then LS tracking resumes; with `CLKCTRL_RDY_ON_CLKSW_EN`, `rdy`=0 from the request until state==LS.
- Re-assert `hsclk_sel` during HS2LS -> return to HS with `clkout` staying high for `div_q`+1 cycles, then normal toggling.
- Assert `rst` for 1 cycle mid-HS -> next cycle: `clkout`=0, state LS, `cnt`=0, `clk_rise`=`clk_fall`=0.

Source files
------------

// File: rtl/clkctrl_pkg.sv
// clkctrl_pkg: shared constants for the single-clock PHI2 controller.
// Holds the FSM state encoding, the default parameter values and a helper
// that turns a divide select into the resulting clkout period in hsclk cycles.
package clkctrl_pkg;

   localparam int DEFAULT_DIV_W       = 2;
   localparam int DEFAULT_SYNC_STAGES = 2;

   typedef logic [1:0] state_t;

   localparam state_t ST_LS    = 2'd0;
   localparam state_t ST_HS    = 2'd1;
   localparam state_t ST_HS2LS = 2'd2;

   // Full clkout period, in hsclk_in cycles, for a given divide select.
   function automatic int div_ratio(input int sel);
      return 2 * (sel + 1);
   endfunction

endpackage

// File: rtl/clkctrl_sync_sync_bits.sv
// sync_bits: STAGES-deep single-bit synchroniser with synchronous reset.
// Brings the host low-speed clock into the hsclk_in domain as plain data.
module sync_bits
   import clkctrl_pkg::*;
#(
   parameter int STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic d_out
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the asynchronous input one stage deeper every cycle.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_in};
   end

   // Synchroniser flops, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/clkctrl_sync.sv
// clkctrl_sync: generates the 65816 PHI2 clock from hsclk_in, either by
// programmable division or by tracking a synchronised lsclk_in. Source
// switches only happen while clkout is high so no phase is ever shortened.
// Optional feature macro: CLKCTRL_RDY_ON_CLKSW_EN (rdy drops during a switch).
module clkctrl_sync
   import clkctrl_pkg::*;
#(
   parameter int DIV_W       = DEFAULT_DIV_W,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic             hsclk_in,
   input  logic             rst,
   input  logic             lsclk_in,
   input  logic             hsclk_sel,
   input  logic [DIV_W-1:0] cpuclk_div_sel,
   output logic             clkout,
   output logic             clk_rise,
   output logic             clk_fall,
   output logic             hsclk_selected,
   output logic             lsclk_selected,
   output logic             rdy
);

   logic             ls_s;
   logic             ls_p_q, ls_p_d;
   logic             ls_rise, ls_fall;
   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_sel_q, div_sel_d;
   logic             clkout_q, clkout_d;
   logic             clk_rise_q, clk_rise_d;
   logic             clk_fall_q, clk_fall_d;

   sync_bits #(
      .STAGES(SYNC_STAGES)
   ) u_ls_sync (
      .clk  (hsclk_in),
      .rst  (rst),
      .d_in (lsclk_in),
      .d_out(ls_s)
   );

   // Edge detection on the synchronised low-speed clock.
   always_comb begin
      ls_p_d  = ls_s;
      ls_rise = ls_s & ~ls_p_q;
      ls_fall = ~ls_s & ls_p_q;
   end

   // Source-selection FSM: LS tracking, HS division, and the HS2LS stretch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_sel_d = div_sel_q;
      clkout_d  = clkout_q;
      case (state_q)
         ST_LS: begin
            clkout_d = ls_s;
            if (ls_rise && hsclk_sel) begin
               clkout_d  = 1'b1;
               cnt_d     = '0;
               div_sel_d = cpuclk_div_sel;
               state_d   = ST_HS;
            end
         end
         ST_HS: begin
            if (cnt_q != div_sel_q) begin
               cnt_d = cnt_q + DIV_W'(1);
            end else begin
               cnt_d     = '0;
               div_sel_d = cpuclk_div_sel;
               if (clkout_q && !hsclk_sel) begin
                  state_d = ST_HS2LS;
               end else begin
                  clkout_d = ~clkout_q;
               end
            end
         end
         ST_HS2LS: begin
            clkout_d = 1'b1;
            if (ls_fall) begin
               clkout_d = 1'b0;
               state_d  = ST_LS;
            end else if (hsclk_sel) begin
               cnt_d     = '0;
               div_sel_d = cpuclk_div_sel;
               state_d   = ST_HS;
            end
         end
         default: begin
            state_d  = ST_LS;
            cnt_d    = '0;
            clkout_d = 1'b0;
         end
      endcase
   end

   // Phase-edge strobes line up with the first cycle of each new clkout level.
   always_comb begin
      clk_rise_d = clkout_d & ~clkout_q;
      clk_fall_d = ~clkout_d & clkout_q;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge hsclk_in) begin
      if (rst) begin
         state_q    <= ST_LS;
         cnt_q      <= '0;
         div_sel_q  <= '0;
         clkout_q   <= 1'b0;
         clk_rise_q <= 1'b0;
         clk_fall_q <= 1'b0;
         ls_p_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_sel_q  <= div_sel_d;
         clkout_q   <= clkout_d;
         clk_rise_q <= clk_rise_d;
         clk_fall_q <= clk_fall_d;
         ls_p_q     <= ls_p_d;
      end
   end

   assign clkout         = clkout_q;
   assign clk_rise       = clk_rise_q;
   assign clk_fall       = clk_fall_q;
   assign hsclk_selected = (state_q == ST_HS);
   assign lsclk_selected = (state_q == ST_LS);

`ifdef CLKCTRL_RDY_ON_CLKSW_EN
   assign rdy = hsclk_sel ? (state_q == ST_HS) : (state_q == ST_LS);
`else
   assign rdy = 1'b1;
`endif

endmodule

// File: tb/tb_clkctrl_sync.sv
// tb_clkctrl_sync: directed scenarios followed by randomized traffic,
// compared every cycle against a phase-length model of the clock controller.
module tb_clkctrl_sync;

   localparam int DIV_W       = 2;
   localparam int SYNC_STAGES = 2;

   localparam int MODE_TRACK   = 0;
   localparam int MODE_DIVIDE  = 1;
   localparam int MODE_STRETCH = 2;

   logic             hsclk_in = 1'b0;
   logic             rst;
   logic             lsclk_in;
   logic             hsclk_sel;
   logic [DIV_W-1:0] cpuclk_div_sel;
   logic             clkout;
   logic             clk_rise;
   logic             clk_fall;
   logic             hsclk_selected;
   logic             lsclk_selected;
   logic             rdy;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state: mode, current clock level, cycles left in phase.
   int m_mode;
   bit m_clk;
   bit m_rise;
   bit m_fall;
   int m_left;
   bit ls_hist[$];

   // Low-speed clock generator state.
   int ls_half;
   int ls_cnt;
   bit ls_random;

   clkctrl_sync #(
      .DIV_W      (DIV_W),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .hsclk_in      (hsclk_in),
      .rst           (rst),
      .lsclk_in      (lsclk_in),
      .hsclk_sel     (hsclk_sel),
      .cpuclk_div_sel(cpuclk_div_sel),
      .clkout        (clkout),
      .clk_rise      (clk_rise),
      .clk_fall      (clk_fall),
      .hsclk_selected(hsclk_selected),
      .lsclk_selected(lsclk_selected),
      .rdy           (rdy)
   );

   // Free-running high-speed clock.
   always #5 hsclk_in = ~hsclk_in;

   task automatic modelReset();
      m_mode = MODE_TRACK;
      m_clk  = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_left = 0;
      ls_hist.delete();
      for (int i = 0; i <= SYNC_STAGES; i++) ls_hist.push_back(1'b0);
   endtask

   // Advance the model across one rising edge using the inputs now applied.
   // ls_hist[0] is the most recent sample of lsclk_in; the synchronised
   // level is the sample taken SYNC_STAGES edges ago.
   task automatic modelStep();
      bit ls_now, ls_prev, rise, fall, old_clk;
      if (rst) begin
         modelReset();
         return;
      end
      ls_now  = ls_hist[SYNC_STAGES-1];
      ls_prev = ls_hist[SYNC_STAGES];
      rise    = ls_now && !ls_prev;
      fall    = !ls_now && ls_prev;
      old_clk = m_clk;
      if (m_mode == MODE_TRACK) begin
         m_clk = ls_now;
         if (rise && hsclk_sel) begin
            m_clk  = 1'b1;
            m_mode = MODE_DIVIDE;
            m_left = int'(cpuclk_div_sel) + 1;
         end
      end else if (m_mode == MODE_DIVIDE) begin
         if (m_left > 1) begin
            m_left--;
         end else if (m_clk && !hsclk_sel) begin
            m_mode = MODE_STRETCH;
         end else begin
            m_clk  = !m_clk;
            m_left = int'(cpuclk_div_sel) + 1;
         end
      end else begin
         if (fall) begin
            m_clk  = 1'b0;
            m_mode = MODE_TRACK;
         end else if (hsclk_sel) begin
            m_mode = MODE_DIVIDE;
            m_left = int'(cpuclk_div_sel) + 1;
         end
      end
      m_rise = m_clk && !old_clk;
      m_fall = !m_clk && old_clk;
      ls_hist.push_front(lsclk_in);
      void'(ls_hist.pop_back());
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, observed, expected);
      end
   endtask

   task automatic checkOutput();
      logic exp_rdy;
`ifdef CLKCTRL_RDY_ON_CLKSW_EN
      exp_rdy = hsclk_sel ? (m_mode == MODE_DIVIDE) : (m_mode == MODE_TRACK);
`else
      exp_rdy = 1'b1;
`endif
      checkBit("clkout",         clkout,         m_clk);
      checkBit("clk_rise",       clk_rise,       m_rise);
      checkBit("clk_fall",       clk_fall,       m_fall);
      checkBit("hsclk_selected", hsclk_selected, m_mode == MODE_DIVIDE);
      checkBit("lsclk_selected", lsclk_selected, m_mode == MODE_TRACK);
      checkBit("rdy",            rdy,            exp_rdy);
   endtask

   task automatic advanceLs();
      ls_cnt++;
      if (ls_cnt >= ls_half) begin
         lsclk_in = ~lsclk_in;
         ls_cnt   = 0;
         if (ls_random) ls_half = $urandom_range(2, 10);
      end
   endtask

   // Check the previous cycle, apply new inputs, then step the model.
   task automatic oneCycle(input bit r, input bit hs, input logic [DIV_W-1:0] sel);
      @(negedge hsclk_in);
      checkOutput();
      rst            = r;
      hsclk_sel      = hs;
      cpuclk_div_sel = sel;
      advanceLs();
      modelStep();
   endtask

   task automatic applyStimulus(input bit r, input bit hs, input logic [DIV_W-1:0] sel,
                                input int cycles);
      for (int i = 0; i < cycles; i++) oneCycle(r, hs, sel);
   endtask

   task automatic randomTraffic(input int cycles);
      bit               hs;
      logic [DIV_W-1:0] sel;
      bit               r;
      hs  = hsclk_sel;
      sel = cpuclk_div_sel;
      for (int i = 0; i < cycles; i++) begin
         if ($urandom_range(0, 39) == 0) hs = ~hs;
         if ($urandom_range(0, 11) == 0) sel = DIV_W'($urandom_range(0, (1 << DIV_W) - 1));
         r = ($urandom_range(0, 399) == 0);
         oneCycle(r, hs, sel);
      end
   endtask

   initial begin
      rst            = 1'b1;
      lsclk_in       = 1'b0;
      hsclk_sel      = 1'b0;
      cpuclk_div_sel = '0;
      ls_half        = 8;
      ls_cnt         = 0;
      ls_random      = 1'b0;
      modelReset();
      repeat (2) @(posedge hsclk_in);

      // LS tracking with a 16-cycle host clock; first check sees reset values.
      applyStimulus(1'b0, 1'b0, 2'd0, 64);

      // Request HS with divide select 3 (4 high / 4 low).
      applyStimulus(1'b0, 1'b1, 2'd3, 48);

      // Shrink the divide mid-phase; current phase completes first.
      applyStimulus(1'b0, 1'b1, 2'd3, 3);
      applyStimulus(1'b0, 1'b1, 2'd0, 16);

      // Back to divide 3, then drop hsclk_sel and return to LS tracking.
      applyStimulus(1'b0, 1'b1, 2'd3, 12);
      applyStimulus(1'b0, 1'b0, 2'd3, 48);

      // Abort an HS to LS switch with a slow host clock.
      ls_half = 20;
      applyStimulus(1'b0, 1'b1, 2'd1, 60);
      applyStimulus(1'b0, 1'b0, 2'd1, 6);
      applyStimulus(1'b0, 1'b1, 2'd2, 30);

      // Single-cycle reset in the middle of HS operation.
      applyStimulus(1'b1, 1'b1, 2'd2, 1);
      applyStimulus(1'b0, 1'b1, 2'd2, 40);

      // Randomized host clock, selects and occasional resets.
      ls_random = 1'b1;
      randomTraffic(4000);

      @(negedge hsclk_in);
      checkOutput();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
